snowv_stream_ctrl: RTL and testbench
====================================

Name: snowv_stream_ctrl

Overview:
Sequencer that sits directly upstream of the SNOW-V LFSR/FSM datapath and downstream of it on the keystream side.
- Accepts a key/IV pair over a valid/ready handshake and drives the core's load, advance, init-mode and R1 key-XOR controls through the 16 initialisation rounds.
- Then forwards the core's 128-bit keystream words to a consumer with full backpressure, stepping the core only when a word can be taken.
- Replaces free-running, delay-based sequencing with a deterministic, reset-controlled schedule.

Parameters:
INIT_ROUNDS, 16, initialisation steps before keystream output
CNT_W, 32, width of block counter and block-count request

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
key_in  in  256  session key
iv_in  in  128  IV
nblk_in  in  CNT_W  keystream words requested; 0 = unlimited
kiv_valid  in  1  key/IV/nblk offered
kiv_ready  out  1  controller idle, accepts offer
abort  in  1  synchronous abort of current session
core_key  out  256  registered key to core
core_iv  out  128  registered IV to core
core_load  out  1  one-cycle pulse: core loads LFSRs from core_key/core_iv, clears R1-R3
core_adv  out  1  core performs one step this cycle
core_init_mode  out  1  core feeds z back into LFSR-A (init step)
core_r1_kxor  out  2  01: R1 ^= key[127:0]; 10: R1 ^= key[255:128]; 00 none
core_z  in  128  core keystream for current state (combinational)
ks_data  out  128  keystream word
ks_valid  out  1  ks_data valid
ks_ready  in  1  consumer accepts
busy  out  1  not IDLE
done  out  1  one-cycle pulse when last requested word accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except kiv_ready=1; counters, core_key, core_iv cleared.
- States: IDLE -> LOAD -> INIT -> STREAM -> IDLE.
- IDLE:
  - kiv_ready=1.
  - On kiv_valid: latch key_in, iv_in, nblk_in into core_key, core_iv, nblk_reg; go to LOAD.
- LOAD (1 cycle): core_load=1, core_adv=0, round counter=0; go to INIT.
- INIT (INIT_ROUNDS cycles):
  - core_adv=1 and core_init_mode=1 every cycle.
  - core_r1_kxor=01 at round INIT_ROUNDS-2, =10 at round INIT_ROUNDS-1, else 00.
  - After round INIT_ROUNDS-1, go to STREAM.
- STREAM (ks_data/ks_valid form a registered output slot):
  - Define take = (!ks_valid | ks_ready) & more, where more = (nblk_reg==0) | (issued < nblk_reg).
  - On take: ks_data <= core_z, ks_valid <= 1, core_adv=1 (same cycle, init_mode=0), issued++.
  - If ks_valid & ks_ready & !take: ks_valid <= 0.
  - First ks_valid asserts 1 cycle after entering STREAM; with ks_ready held high, one word per cycle.
  - ks_data and ks_valid are stable while ks_valid & !ks_ready.
  - Words are the core's z for consecutive core states, with none skipped or duplicated under any ks_ready pattern.
- Session end:
  - When nblk_reg!=0 and the nblk_reg-th word is accepted: done=1 for one cycle; go to IDLE.
  - nblk_reg=0: stream indefinitely; the issued counter wraps mod 2^CNT_W with no effect on behaviour.
- Handshake rules:
  - kiv_valid outside IDLE is ignored (kiv_ready=0).
  - kiv_valid in the same cycle as done is not accepted until the next cycle.
- abort (any non-IDLE state): next state IDLE; ks_valid cleared; no done; core_adv=0 in the abort cycle.
- Reset mid-session behaves identically to power-on reset.
- core_adv is never asserted in IDLE or LOAD, nor while the output slot is full and ks_ready=0.

Decomposition:
- Package snowv_pkg:
  - state enum (IDLE, LOAD, INIT, STREAM)
  - KEY_W=256, IV_W=128, Z_W=128
  - R1_KXOR_LO=2'b01, R1_KXOR_HI=2'b10
- One natural sub-module: snowv_ks_slot, the one-entry registered output slot with valid/ready and take logic.

Test Plan:
- Reset → kiv_ready=1, busy=0, ks_valid=0, core_adv=0; release rst_n and hold 5 cycles → no change.
- Sequencing: key=256'h0, iv=128'h0, nblk=4, ks_ready=1.
  - core_load pulse at cycle 1; core_adv & init_mode for cycles 2-17; r1_kxor=01 at cycle 16, 10 at cycle 17.
  - ks_valid on cycles 19-22 carrying core_z of successive states; done on cycle 22; kiv_ready=1 at cycle 23.
- Backpressure: nblk=8, ks_ready toggling 1,0,0,1,…
  - Exactly 8 words, matching the core model's z sequence, with no gaps or duplicates.
  - core_adv never asserted while the slot is full and ks_ready=0.
- Unlimited mode: nblk=0, ks_ready=1 for 1000 cycles → continuous words; done never pulses; abort → IDLE next cycle with ks_valid=0.
- Mid-INIT events:
  - abort at init round 7 → no further core_adv, IDLE; a new key/IV is then accepted and runs a full 16-round init.
  - Repeat with rst_n low at round 7 → same outcome.
- kiv_valid held high during STREAM → ignored; a second session starts only after done, using the values present then.

Source files
------------

// File: rtl/snowv_pkg.sv
// Shared types and constants for the SNOW-V stream controller.
//   state_e        : controller session states
//   KEY_W/IV_W/Z_W : key, IV and keystream word widths
//   R1_KXOR_*      : encodings of the core's R1 key-XOR select
package snowv_pkg;

  localparam int unsigned KEY_W = 256;
  localparam int unsigned IV_W  = 128;
  localparam int unsigned Z_W   = 128;

  localparam logic [1:0] R1_KXOR_NONE = 2'b00;
  localparam logic [1:0] R1_KXOR_LO   = 2'b01;  // R1 ^= key[127:0]
  localparam logic [1:0] R1_KXOR_HI   = 2'b10;  // R1 ^= key[255:128]

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StInit,
    StStream
  } state_e;

endpackage

// File: rtl/snowv_ks_slot.sv
// One-entry registered keystream output slot with valid/ready.
//   clk, rst_n  : clock, async active-low reset
//   en          : slot may capture a new word this cycle
//   more        : session still owes words
//   clear       : drop any held word (abort)
//   z           : core keystream for the current core state
//   ready       : consumer accepts
//   data, valid : registered output word and its valid
//   take        : capturing z this cycle; the core must step in the same cycle
module snowv_ks_slot
  import snowv_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           more,
  input  logic           clear,
  input  logic [Z_W-1:0] z,
  input  logic           ready,
  output logic [Z_W-1:0] data,
  output logic           valid,
  output logic           take
);

  logic [Z_W-1:0] data_q, data_d;
  logic           valid_q, valid_d;

  // Capture only when the slot is empty or being drained, so no word is lost.
  assign take = en & (~valid_q | ready) & more;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (take) begin
      valid_d = 1'b1;
      data_d  = z;
    end else if (valid_q & ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/snowv_stream_ctrl.sv
// Session sequencer for a SNOW-V core: accepts key/IV/block count, loads the
// core, runs INIT_ROUNDS initialisation steps, then streams keystream words
// with full backpressure, stepping the core only when a word is captured.
//   clk, rst_n                 : clock, async active-low reset
//   key_in, iv_in, nblk_in     : session offer (nblk 0 = unlimited)
//   kiv_valid, kiv_ready       : offer handshake (ready only when idle)
//   abort                      : synchronous session abort
//   core_key, core_iv          : latched key/IV to core
//   core_load, core_adv        : core load pulse, core step enable
//   core_init_mode, core_r1_kxor : init-step controls
//   core_z                     : core keystream for its current state
//   ks_data, ks_valid, ks_ready: keystream output
//   busy, done                 : not idle; last requested word accepted
module snowv_stream_ctrl
  import snowv_pkg::*;
#(
  parameter int unsigned INIT_ROUNDS = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic [IV_W-1:0]  iv_in,
  input  logic [CNT_W-1:0] nblk_in,
  input  logic             kiv_valid,
  output logic             kiv_ready,
  input  logic             abort,
  output logic [KEY_W-1:0] core_key,
  output logic [IV_W-1:0]  core_iv,
  output logic             core_load,
  output logic             core_adv,
  output logic             core_init_mode,
  output logic [1:0]       core_r1_kxor,
  input  logic [Z_W-1:0]   core_z,
  output logic [Z_W-1:0]   ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned RndW = (INIT_ROUNDS > 1) ? $clog2(INIT_ROUNDS) : 1;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IV_W-1:0]  iv_q, iv_d;
  logic [CNT_W-1:0] nblk_q, nblk_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [RndW-1:0]  round_q, round_d;

  logic more, take, slot_en, slot_clear;

  // nblk 0 streams forever; issued wraps harmlessly in that mode.
  assign more       = (nblk_q == '0) | (issued_q < nblk_q);
  assign slot_en    = (state_q == StStream) & ~abort;
  assign slot_clear = (state_q != StIdle) & abort;

  snowv_ks_slot u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (slot_en),
    .more  (more),
    .clear (slot_clear),
    .z     (core_z),
    .ready (ks_ready),
    .data  (ks_data),
    .valid (ks_valid),
    .take  (take)
  );

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    iv_d           = iv_q;
    nblk_d         = nblk_q;
    issued_d       = issued_q;
    round_d        = round_q;
    kiv_ready      = 1'b0;
    core_load      = 1'b0;
    core_adv       = 1'b0;
    core_init_mode = 1'b0;
    core_r1_kxor   = R1_KXOR_NONE;
    done           = 1'b0;

    unique case (state_q)
      StIdle: begin
        kiv_ready = 1'b1;
        if (kiv_valid) begin
          key_d    = key_in;
          iv_d     = iv_in;
          nblk_d   = nblk_in;
          issued_d = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          core_load = 1'b1;
          round_d   = '0;
          state_d   = StInit;
        end
      end
      StInit: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          core_adv       = 1'b1;
          core_init_mode = 1'b1;
          if (round_q == RndW'(INIT_ROUNDS - 2)) core_r1_kxor = R1_KXOR_LO;
          if (round_q == RndW'(INIT_ROUNDS - 1)) core_r1_kxor = R1_KXOR_HI;
          round_d = round_q + RndW'(1);
          if (round_q == RndW'(INIT_ROUNDS - 1)) state_d = StStream;
        end
      end
      StStream: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          core_adv = take;
          if (take) issued_d = issued_q + CNT_W'(1);
          // Once issued reaches nblk the slot holds the final word.
          if ((nblk_q != '0) && (issued_q == nblk_q) && ks_valid && ks_ready) begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      key_q    <= '0;
      iv_q     <= '0;
      nblk_q   <= '0;
      issued_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      iv_q     <= iv_d;
      nblk_q   <= nblk_d;
      issued_q <= issued_d;
      round_q  <= round_d;
    end
  end

  assign core_key = key_q;
  assign core_iv  = iv_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_snowv_stream_ctrl.sv
module tb_snowv_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key_in;
  logic [127:0] iv_in;
  logic [31:0]  nblk_in;
  logic         kiv_valid;
  logic         kiv_ready;
  logic         abort;
  logic [255:0] core_key;
  logic [127:0] core_iv;
  logic         core_load;
  logic         core_adv;
  logic         core_init_mode;
  logic [1:0]   core_r1_kxor;
  logic [127:0] core_z;
  logic [127:0] ks_data;
  logic         ks_valid;
  logic         ks_ready;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  snowv_stream_ctrl #(
    .INIT_ROUNDS (16),
    .CNT_W       (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_in         (key_in),
    .iv_in          (iv_in),
    .nblk_in        (nblk_in),
    .kiv_valid      (kiv_valid),
    .kiv_ready      (kiv_ready),
    .abort          (abort),
    .core_key       (core_key),
    .core_iv        (core_iv),
    .core_load      (core_load),
    .core_adv       (core_adv),
    .core_init_mode (core_init_mode),
    .core_r1_kxor   (core_r1_kxor),
    .core_z         (core_z),
    .ks_data        (ks_data),
    .ks_valid       (ks_valid),
    .ks_ready       (ks_ready),
    .busy           (busy),
    .done           (done)
  );

  // Stand-in core: a step counter seeded from key/IV; z is a fixed mix of it.
  function automatic logic [127:0] z_of(input logic [31:0] s);
    return {s, s ^ 32'hDEADBEEF, ~s, s + 32'h1234_5678};
  endfunction

  function automatic logic [31:0] seed_of(input logic [255:0] k, input logic [127:0] v);
    return k[31:0] ^ v[31:0];
  endfunction

  logic [31:0] cst;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cst <= '0;
    else if (core_load) cst <= core_key[31:0] ^ core_iv[31:0];
    else if (core_adv)  cst <= cst + 32'd1;
  end
  assign core_z = z_of(cst);

  // Passive monitor, sampled on the falling edge.
  logic [127:0] words[$];
  int           n_done = 0, n_adv = 0, n_init_adv = 0, n_load = 0;
  int           n_stall_adv = 0, n_unstable = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ks_valid && ks_ready) words.push_back(ks_data);
      if (done) n_done <= n_done + 1;
      if (core_adv) n_adv <= n_adv + 1;
      if (core_adv && core_init_mode) n_init_adv <= n_init_adv + 1;
      if (core_load) n_load <= n_load + 1;
      if (core_adv && ks_valid && !ks_ready) n_stall_adv <= n_stall_adv + 1;
      if (prev_stall && (!ks_valid || ks_data != prev_data)) n_unstable <= n_unstable + 1;
      prev_stall <= ks_valid && !ks_ready;
      prev_data  <= ks_data;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer a session, drive ks_ready (optionally 1,0,0,1 pattern), wait for done.
  task automatic run_session(input logic [255:0] k, input logic [127:0] v,
                             input logic [31:0] n, input bit bp, input int bound,
                             output bit got_done);
    @(posedge clk); #1;
    key_in = k; iv_in = v; nblk_in = n; kiv_valid = 1'b1; ks_ready = 1'b1;
    got_done = 1'b0;
    for (int c = 0; c < bound && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      @(posedge clk); #1;
      kiv_valid = 1'b0;
      if (bp) ks_ready = (((c + 1) % 4) == 0) || (((c + 1) % 4) == 3);
    end
    ks_ready = 1'b1;
  endtask

  // Check the words of a session starting at queue index base.
  task automatic check_words(input string tag, input int base, input int cnt,
                             input logic [31:0] seed);
    for (int i = 0; i < cnt; i++) begin
      if (base + i < words.size())
        check(tag, words[base + i], z_of(seed + 32'd16 + 32'(i)));
      else
        check(tag, 128'hx, z_of(seed + 32'd16 + 32'(i)));
    end
  endtask

  // Abort or reset at init round 7, then confirm a clean fresh session.
  task automatic mid_init(input bit use_reset);
    logic [255:0] k2;
    logic [127:0] v2;
    int           adv_base, init_base, load_base, wbase;
    bit           ok;
    @(posedge clk); #1;
    key_in = {8{32'h0BAD_F00D}}; iv_in = {4{32'h0000_0077}}; nblk_in = 32'd3;
    kiv_valid = 1'b1;
    @(posedge clk); #1;
    kiv_valid = 1'b0;
    repeat (8) @(posedge clk);  // now in cycle 9: init round 7
    #1;
    if (use_reset) rst_n = 1'b0;
    else abort = 1'b1;
    @(negedge clk);
    check(use_reset ? "rst_adv" : "abort_adv", core_adv, 1'b0);
    if (use_reset) check("rst_key", core_key, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; abort = 1'b0;
    adv_base = n_adv;
    @(negedge clk);
    check(use_reset ? "rst_idle" : "abort_idle", {busy, kiv_ready, ks_valid}, 3'b010);
    repeat (5) @(negedge clk);
    check(use_reset ? "rst_noadv" : "abort_noadv", 32'(n_adv - adv_base), 0);

    k2 = {8{32'h1357_9BDF}}; v2 = {4{32'h2468_ACE0}};
    init_base = n_init_adv; load_base = n_load; wbase = words.size();
    run_session(k2, v2, 32'd2, 1'b0, 60, ok);
    check("re_done", ok, 1'b1);
    check("re_load", 32'(n_load - load_base), 1);
    check("re_init16", 32'(n_init_adv - init_base), 16);
    check_words("re_word", wbase, 2, seed_of(k2, v2));
  endtask

  logic [31:0] v_load, v_adv, v_im, v_klo, v_khi, v_ksv, v_done, v_rdy, v_busy;

  initial begin
    int           wbase, dbase, sbase, ubase, bad;
    bit           ok;
    logic [255:0] ka, kb;
    logic [127:0] va, vb;

    rst_n = 1'b0; key_in = '0; iv_in = '0; nblk_in = '0;
    kiv_valid = 1'b0; abort = 1'b0; ks_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outs", {kiv_ready, busy, ks_valid, core_adv, core_load, done}, 6'b100000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_hold", {kiv_ready, busy, ks_valid, core_adv, core_load}, 5'b10000);
    end

    // Cycle-accurate sequencing, nblk=4
    ks_ready = 1'b1;
    wbase = words.size();
    dbase = n_done;
    @(posedge clk); #1;
    key_in = '0; iv_in = '0; nblk_in = 32'd4; kiv_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      v_load[c] = core_load; v_adv[c] = core_adv; v_im[c] = core_init_mode;
      v_klo[c]  = (core_r1_kxor == 2'b01); v_khi[c] = (core_r1_kxor == 2'b10);
      v_ksv[c]  = ks_valid; v_done[c] = done; v_rdy[c] = kiv_ready; v_busy[c] = busy;
      @(posedge clk); #1;
      kiv_valid = 1'b0;
    end
    check("seq_load",  v_load[23:0], 24'h00_0002);
    check("seq_adv",   v_adv[23:0],  24'h3F_FFFC);
    check("seq_imode", v_im[23:0],   24'h03_FFFC);
    check("seq_kxlo",  v_klo[23:0],  24'h01_0000);
    check("seq_kxhi",  v_khi[23:0],  24'h02_0000);
    check("seq_ksv",   v_ksv[23:0],  24'h78_0000);
    check("seq_done",  v_done[23:0], 24'h40_0000);
    check("seq_kready", v_rdy[23:0], 24'h80_0001);
    check("seq_busy",  v_busy[23:0], 24'h7F_FFFE);
    check("seq_nwords", 32'(words.size() - wbase), 4);
    check_words("seq_word", wbase, 4, 32'd0);

    // Backpressure, nblk=8, ready 1,0,0,1,...
    ka = {8{32'hCAFE_0001}}; va = {4{32'h0000_1111}};
    wbase = words.size(); dbase = n_done; sbase = n_stall_adv; ubase = n_unstable;
    run_session(ka, va, 32'd8, 1'b1, 200, ok);
    check("bp_done_seen", ok, 1'b1);
    @(negedge clk);
    check("bp_nwords", 32'(words.size() - wbase), 8);
    check_words("bp_word", wbase, 8, seed_of(ka, va));
    check("bp_stall_adv", 32'(n_stall_adv - sbase), 0);
    check("bp_stable", 32'(n_unstable - ubase), 0);
    check("bp_ndone", 32'(n_done - dbase), 1);
    check("bp_idle", {busy, kiv_ready}, 2'b01);

    // Unlimited mode for 1000 words, then abort
    ka = {8{32'h5555_0F0F}}; va = {4{32'h0000_00A0}};
    wbase = words.size(); dbase = n_done;
    @(posedge clk); #1;
    key_in = ka; iv_in = va; nblk_in = 32'd0; kiv_valid = 1'b1; ks_ready = 1'b1;
    @(posedge clk); #1;
    kiv_valid = 1'b0;
    repeat (1017) @(posedge clk);  // cycle 1018
    #1;
    abort = 1'b1;
    @(negedge clk);
    check("unl_abort_adv", core_adv, 1'b0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("unl_abort_idle", {busy, ks_valid, kiv_ready}, 3'b001);
    check("unl_nwords", 32'(words.size() - wbase), 1000);
    bad = 0;
    for (int i = 0; i < 1000 && wbase + i < words.size(); i++)
      if (words[wbase + i] !== z_of(seed_of(ka, va) + 32'd16 + 32'(i))) bad++;
    check("unl_data_bad", 32'(bad), 0);
    check("unl_no_done", 32'(n_done - dbase), 0);

    // Abort / reset during init
    mid_init(1'b0);
    mid_init(1'b1);

    // kiv_valid held through STREAM; next session starts only after done
    ka = {8{32'hA0A0_0003}}; va = {4{32'h0000_0030}};
    kb = {8{32'hB0B0_0004}}; vb = {4{32'h0000_0040}};
    wbase = words.size(); dbase = n_done;
    @(posedge clk); #1;
    key_in = ka; iv_in = va; nblk_in = 32'd3; kiv_valid = 1'b1; ks_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    key_in = kb; iv_in = vb; nblk_in = 32'd2;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      else @(posedge clk);
    end
    check("hold_done_a", ok, 1'b1);
    check("hold_core_key_a", core_key[127:0], ka[127:0]);
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_idle_gap", {busy, kiv_ready}, 2'b01);
    @(posedge clk); #1;
    kiv_valid = 1'b0;
    @(negedge clk);
    check("hold_load_b", core_load, 1'b1);
    check("hold_core_key_b", core_key[127:0], kb[127:0]);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      else @(posedge clk);
    end
    check("hold_done_b", ok, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("hold_nwords", 32'(words.size() - wbase), 5);
    check_words("hold_word_a", wbase, 3, seed_of(ka, va));
    check_words("hold_word_b", wbase + 3, 2, seed_of(kb, vb) - 32'd0);
    check("hold_ndone", 32'(n_done - dbase), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
